// File: rtl/nios_debug_pkg.sv
// Shared types and default parameters for the Nios debug slave system-clock side.
package nios_debug_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } state_t;

    localparam int unsigned SR_WIDTH_DEF    = 38;
    localparam int unsigned IR_WIDTH_DEF    = 2;
    localparam int unsigned SYNC_STAGES_DEF = 2;
    localparam int unsigned ACT_BIT_DEF     = 34;

    // Number of strobe lines for the default IR width
    localparam int unsigned NUM_IR = 2 ** IR_WIDTH_DEF;

endpackage

// File: rtl/nios_debug_sync_edge.sv
// Level synchroniser followed by a delay flop; rise pulses once per synchronised rising level.
module nios_debug_sync_edge
    import nios_debug_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic clk,
    input  logic reset_n,
    input  logic async_in,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   dly_q;

    // Synchroniser chain plus one delay stage for edge detection
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            dly_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
            dly_q  <= sync_q[SYNC_STAGES-1];
        end
    end

    // Rising edge of the synchronised level; the consumer registers it
    assign rise = sync_q[SYNC_STAGES-1] & ~dly_q;

endmodule

// File: rtl/nios_debug_slave_sysclk_sync.sv
// System-clock side of the Nios debug slave: event sync, one-deep command buffer,
// IR decode into action/no-action strobes, overrun flag and accepted-command counter.
module nios_debug_slave_sysclk_sync
    import nios_debug_pkg::*;
#(
    parameter int unsigned SR_WIDTH    = SR_WIDTH_DEF,
    parameter int unsigned IR_WIDTH    = IR_WIDTH_DEF,
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int unsigned ACT_BIT     = ACT_BIT_DEF
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [IR_WIDTH-1:0]      ir_in,
    input  logic [SR_WIDTH-1:0]      sr,
    input  logic                     vs_uir,
    input  logic                     vs_e1dr,
    input  logic                     cmd_ready,
    input  logic                     overrun_clr,
    output logic [SR_WIDTH-1:0]      jdo,
    output logic                     cmd_valid,
    output logic [IR_WIDTH-1:0]      cmd_ir,
    output logic [2**IR_WIDTH-1:0]   take_action,
    output logic [2**IR_WIDTH-1:0]   take_no_action,
    output logic                     uir_strobe,
    output logic                     overrun,
    output logic [7:0]               cmd_count
);

    localparam int unsigned IR_CODES = 2 ** IR_WIDTH;

    state_t              state;
    logic [IR_WIDTH-1:0] ir_reg;
    logic                uir_rise;
    logic                e1dr_rise;
    logic                accept_c;
    logic                capture_c;
    logic                drop_c;
    logic [IR_WIDTH-1:0] ir_next_c;
    logic [IR_CODES-1:0] sel_c;

    nios_debug_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_uir (
        .clk      (clk),
        .reset_n  (reset_n),
        .async_in (vs_uir),
        .rise     (uir_rise)
    );

    nios_debug_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_e1dr (
        .clk      (clk),
        .reset_n  (reset_n),
        .async_in (vs_e1dr),
        .rise     (e1dr_rise)
    );

    // Handshake qualifiers; a new IR bypasses ir_reg when both events coincide
    always_comb begin
        accept_c  = (state == PEND) && cmd_ready;
        capture_c = e1dr_rise && ((state == IDLE) || accept_c);
        drop_c    = e1dr_rise && (state == PEND) && !cmd_ready;
        ir_next_c = uir_rise ? ir_in : ir_reg;
        sel_c     = IR_CODES'(1) << cmd_ir;
    end

    // IR register and update-IR strobe
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ir_reg     <= '0;
            uir_strobe <= 1'b0;
        end else begin
            ir_reg     <= ir_next_c;
            uir_strobe <= uir_rise;
        end
    end

    // Command buffer FSM: capture on e1dr, release on accept
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cmd_valid <= 1'b0;
            jdo       <= '0;
            cmd_ir    <= '0;
        end else if (capture_c) begin
            state     <= PEND;
            cmd_valid <= 1'b1;
            jdo       <= sr;
            cmd_ir    <= ir_next_c;
        end else if (accept_c) begin
            state     <= IDLE;
            cmd_valid <= 1'b0;
        end
    end

    // One-hot decode of the accepted command, old jdo/cmd_ir before any recapture
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            take_action    <= '0;
            take_no_action <= '0;
        end else begin
            take_action    <= (accept_c &&  jdo[ACT_BIT]) ? sel_c : '0;
            take_no_action <= (accept_c && !jdo[ACT_BIT]) ? sel_c : '0;
        end
    end

    // Sticky overrun; a same-cycle drop beats the clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overrun <= 1'b0;
        end else if (drop_c) begin
            overrun <= 1'b1;
        end else if (overrun_clr) begin
            overrun <= 1'b0;
        end
    end

    // Accepted-command counter, wraps naturally
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cmd_count <= '0;
        end else if (accept_c) begin
            cmd_count <= cmd_count + 8'd1;
        end
    end

endmodule
